// File: rtl/debug_telemetry_pkg.sv
// Shared types and constants for the debug telemetry streamer.
// Holds FSM encodings, ASCII/command characters and elaboration helpers; no logic.
package debug_telemetry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SEND,
    ST_EOL
  } tx_state_t;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'
  localparam logic [7:0] CMD_MOTOR = 8'h6D;  // 'm'
  localparam logic [7:0] CMD_DATA  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/debug_telemetry_bin2bcd_seq.sv
// Iterative double-dabble: one shift per cycle, done pulses BITS+1 cycles after start.
// No backpressure; bcd holds its value after done until the next start.
module bin2bcd_seq #(
  parameter int BITS   = 24,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BITS-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(BITS + 1);

  logic [BITS-1:0]     sh;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= CW'(BITS);
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt != '0) begin
          bcd <= {adj[4*DIGITS-2:0], sh[BITS-1]};
          sh  <= sh << 1;
          cnt <= cnt - 1'b1;
        end else begin
          // Extra cycle after the last shift gives the BITS+1 done timing.
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_telemetry.sv
// Tick-driven ASCII channel streamer plus single-char command parser; first byte >= DATA_BITS+3 cycles after tmr.
// Bytes go out only when tx_busy is low, never on back-to-back cycles; ticks arriving mid-frame are dropped and counted.
module debug_telemetry
  import debug_telemetry_pkg::*;
#(
  parameter int         CHANNELS   = 4,
  parameter int         DATA_BITS  = 24,
  parameter int         DIGITS     = 8,
  parameter logic [7:0] LABEL_BASE = 8'h41
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tmr,
  input  logic [CHANNELS*DATA_BITS-1:0] data,
  input  logic [7:0]                    rx_data,
  input  logic                          new_rx_data,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  output logic                          reset_req,
  output logic                          motor_arm,
  output logic                          log_en,
  output logic                          stream_en,
  output logic                          frame_busy,
  output logic [7:0]                    overrun_cnt
);

  localparam int              CH_W    = width_of(CHANNELS);
  localparam int              BP_W    = width_of(DIGITS + 3);
  localparam logic [BP_W-1:0] BP_LAST = BP_W'(DIGITS + 2);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("debug_telemetry: CHANNELS must be 1..8");
  end
  if (pow10(DIGITS) <= ((64'd1 << DATA_BITS) - 64'd1)) begin : g_bad_digits
    $error("debug_telemetry: DIGITS too small for DATA_BITS");
  end

  tx_state_t           state, state_nx;
  logic [CH_W-1:0]     ch;
  logic [BP_W-1:0]     bp;
  logic [DATA_BITS-1:0] snap [CHANNELS];
  logic                cvt_start, cvt_busy, cvt_done;
  logic [4*DIGITS-1:0] bcd;
  logic                issued_q;
  logic                can_issue;
  logic [7:0]          cur_byte;

  bin2bcd_seq #(.BITS(DATA_BITS), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .bin   (snap[ch]),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (bcd)
  );

  always_comb begin
    cur_byte = ASCII_CR;
    if (state == ST_SEND) begin
      if (bp == '0)           cur_byte = LABEL_BASE + 8'(ch);
      else if (bp == BP_W'(1)) cur_byte = ASCII_COLON;
      else if (bp == BP_LAST)  cur_byte = ASCII_SPACE;
      else begin
        // bp 2 is the most significant digit.
        cur_byte = ASCII_ZERO;
        for (int k = 0; k < DIGITS; k++) begin
          if (bp == BP_W'(DIGITS + 1 - k)) cur_byte = ASCII_ZERO + {4'd0, bcd[4*k +: 4]};
        end
      end
    end
  end

  assign can_issue   = (state == ST_SEND || state == ST_EOL) && !tx_busy && !issued_q;
  assign new_tx_data = can_issue;
  assign tx_data     = can_issue ? cur_byte : 8'h00;
  assign frame_busy  = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (tmr && stream_en) state_nx = ST_CONV;
      ST_CONV: if (cvt_done && !cvt_busy) state_nx = ST_SEND;
      ST_SEND: if (can_issue && bp == BP_LAST) state_nx = (ch == CH_LAST) ? ST_EOL : ST_CONV;
      ST_EOL:  if (can_issue) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ch          <= '0;
      bp          <= '0;
      issued_q    <= 1'b0;
      cvt_start   <= 1'b0;
      overrun_cnt <= 8'd0;
      for (int k = 0; k < CHANNELS; k++) snap[k] <= '0;
    end else begin
      state     <= state_nx;
      issued_q  <= can_issue;
      cvt_start <= (state_nx == ST_CONV) && (state != ST_CONV);
      if (state == ST_IDLE && tmr && stream_en) begin
        ch <= '0;
        bp <= '0;
        for (int k = 0; k < CHANNELS; k++) snap[k] <= data[k*DATA_BITS +: DATA_BITS];
      end
      if (state == ST_SEND && can_issue) begin
        bp <= (bp == BP_LAST) ? '0 : bp + 1'b1;
        if (bp == BP_LAST && ch != CH_LAST) ch <= ch + 1'b1;
      end
      if (tmr && state != ST_IDLE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reset_req <= 1'b0;
      motor_arm <= 1'b0;
      log_en    <= 1'b0;
      stream_en <= 1'b1;
    end else begin
      reset_req <= new_rx_data && (rx_data == CMD_RESET);
      if (new_rx_data) begin
        if (rx_data == CMD_MOTOR) motor_arm <= !motor_arm;
        if (rx_data == CMD_DATA)  log_en    <= !log_en;
        if (rx_data == CMD_PAUSE) stream_en <= !stream_en;
      end
    end
  end

endmodule

// File: tb/tb_debug_telemetry.sv
// Bench for debug_telemetry: command table, directed and randomized frames checked against a formatted-string model.
module tb_debug_telemetry;

  localparam int CH = 2;
  localparam int DB = 24;
  localparam int DG = 8;
  localparam int FL = CH * (DG + 3) + 1;

  logic              clk = 1'b0;
  logic              rst, tmr, new_rx_data, tx_busy;
  logic [CH*DB-1:0]  data;
  logic [7:0]        rx_data, tx_data, overrun_cnt;
  logic              new_tx_data, reset_req, motor_arm, log_en, stream_en, frame_busy;

  debug_telemetry #(.CHANNELS(CH), .DATA_BITS(DB), .DIGITS(DG), .LABEL_BASE(8'h41)) dut (
    .clk(clk), .rst(rst), .tmr(tmr), .data(data), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data), .reset_req(reset_req),
    .motor_arm(motor_arm), .log_en(log_en), .stream_en(stream_en), .frame_busy(frame_busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: captures transmitted bytes and protocol violations at the falling edge.
  logic [7:0]       got[$];
  logic [7:0]       exp_q[$];
  logic [CH*DB-1:0] snap_d = '0;
  int               tmr_cyc = 0, first_cyc = 0;
  int               viol_consec = 0, viol_busy = 0, viol_dat = 0;
  logic             prev_str = 1'b0;

  always @(negedge clk) begin
    if (tmr === 1'b1 && frame_busy === 1'b0 && stream_en === 1'b1) begin
      snap_d  = data;
      tmr_cyc = cyc;
    end
    if (new_tx_data === 1'b1) begin
      got.push_back(tx_data);
      if (got.size() == 1) first_cyc = cyc;
      if (prev_str) viol_consec++;
      if (tx_busy) viol_busy++;
    end else if (tx_data !== 8'h00) begin
      viol_dat++;
    end
    prev_str = (new_tx_data === 1'b1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data = c;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tmr();
    tmr = 1'b1;
    tick();
    tmr = 1'b0;
  endtask

  // Reference model: the frame is the printf rendering of each latched channel.
  task automatic build_exp(input logic [CH*DB-1:0] d);
    exp_q.delete();
    for (int k = 0; k < CH; k++) begin
      string s;
      s = $sformatf("%c:%08d ", 8'(8'h41 + k), d[k*DB +: DB]);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
    exp_q.push_back(8'h0D);
  endtask

  task automatic wait_frame(input string name, input int budget);
    int n;
    n = 0;
    while (frame_busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, 64'(n < budget), 64'd1);
  endtask

  task automatic compare_frame(input string name);
    int m;
    build_exp(snap_d);
    check({name, "_len"}, 64'(got.size()), 64'(FL));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_byte%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_new_tx"},  64'(new_tx_data), 64'd0);
    check({name, "_tx_data"}, 64'(tx_data),     64'd0);
    check({name, "_rreq"},    64'(reset_req),   64'd0);
    check({name, "_motor"},   64'(motor_arm),   64'd0);
    check({name, "_log"},     64'(log_en),      64'd0);
    check({name, "_stream"},  64'(stream_en),   64'd1);
    check({name, "_fbusy"},   64'(frame_busy),  64'd0);
    check({name, "_ovr"},     64'(overrun_cnt), 64'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       motor;
    logic       log_e;
    logic       stream;
    logic       rreq;
  } cmd_vec_t;

  cmd_vec_t vecs[6];
  int       n_before, n;

  initial begin
    rst = 1'b1; tmr = 1'b0; new_rx_data = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("reset");

    // Command table: cumulative expected control state after each byte.
    vecs[0] = '{8'h6D, 1'b1, 1'b0, 1'b1, 1'b0};  // m
    vecs[1] = '{8'h64, 1'b1, 1'b1, 1'b1, 1'b0};  // d
    vecs[2] = '{8'h78, 1'b1, 1'b1, 1'b1, 1'b0};  // x ignored
    vecs[3] = '{8'h4D, 1'b1, 1'b1, 1'b1, 1'b0};  // M ignored (case-sensitive)
    vecs[4] = '{8'h72, 1'b1, 1'b1, 1'b1, 1'b1};  // r
    vecs[5] = '{8'h70, 1'b1, 1'b1, 1'b0, 1'b0};  // p
    tick();
    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].cmd);
      @(negedge clk);
      check($sformatf("cmd%0d_motor", i),  64'(motor_arm), 64'(vecs[i].motor));
      check($sformatf("cmd%0d_log", i),    64'(log_en),    64'(vecs[i].log_e));
      check($sformatf("cmd%0d_stream", i), 64'(stream_en), 64'(vecs[i].stream));
      check($sformatf("cmd%0d_rreq", i),   64'(reset_req), 64'(vecs[i].rreq));
      tick();
      check($sformatf("cmd%0d_rreq_off", i), 64'(reset_req), 64'd0);
    end

    // Paused: tick ignored, nothing sent, nothing counted.
    got.delete();
    pulse_tmr();
    repeat (100) tick();
    check("paused_bytes", 64'(got.size()), 64'd0);
    check("paused_ovr",   64'(overrun_cnt), 64'd0);
    send_cmd(8'h70);
    @(negedge clk);
    check("resume_stream", 64'(stream_en), 64'd1);
    tick();

    // Directed frame from the reference example.
    data = {24'd16777215, 24'd1234};
    got.delete();
    viol_consec = 0;
    pulse_tmr();
    wait_frame("dir", 2000);
    compare_frame("dir");
    check("dir_latency", 64'((first_cyc - tmr_cyc) >= DB + 3), 64'd1);
    check("dir_no_b2b", 64'(viol_consec), 64'd0);

    // Reset after the 5th byte abandons the frame.
    got.delete();
    pulse_tmr();
    n = 0;
    while (got.size() < 5 && n < 500) begin tick(); n++; end
    check("rst_reach5", 64'(n < 500), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    n_before = got.size();
    repeat (100) tick();
    check("midrst_quiet", 64'(got.size()), 64'(n_before));
    data = {24'd42, 24'd9876543};
    got.delete();
    pulse_tmr();
    wait_frame("postrst", 2000);
    compare_frame("postrst");

    // tx_busy held for 50 cycles mid-SEND.
    data = {24'd7, 24'd100000};
    got.delete();
    pulse_tmr();
    n = 0;
    while (got.size() < 3 && n < 500) begin tick(); n++; end
    tx_busy = 1'b1;
    n_before = got.size();
    repeat (50) tick();
    check("busy_hold", 64'(got.size()), 64'(n_before));
    tx_busy = 1'b0;
    wait_frame("busy", 2000);
    compare_frame("busy");

    // Three ticks dropped during one frame.
    data = {24'd555, 24'd0};
    got.delete();
    pulse_tmr();
    for (int i = 0; i < 3; i++) begin
      repeat (5) tick();
      pulse_tmr();
    end
    wait_frame("ovr3", 2000);
    check("ovr3_cnt", 64'(overrun_cnt), 64'd3);
    compare_frame("ovr3");

    // Saturation: tmr held for 300 cycles while the frame is stalled.
    data = {24'd8388608, 24'd99};
    got.delete();
    tx_busy = 1'b1;
    tmr = 1'b1;
    repeat (300) tick();
    tmr = 1'b0;
    check("ovr_sat", 64'(overrun_cnt), 64'd255);
    tx_busy = 1'b0;
    wait_frame("sat", 3000);
    compare_frame("sat");

    // Random frames: data churns every cycle after tmr, random tx_busy.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < CH; k++)
        data[k*DB +: DB] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom);
      got.delete();
      pulse_tmr();
      n = 0;
      while (frame_busy === 1'b1 && n < 5000) begin
        data = {24'($urandom), 24'($urandom)};
        tx_busy = ($urandom_range(0, 3) == 0);
        tick();
        n++;
      end
      tx_busy = 1'b0;
      check($sformatf("rnd%0d_done", f), 64'(n < 5000), 64'd1);
      compare_frame($sformatf("rnd%0d", f));
    end

    check("never_b2b",      64'(viol_consec), 64'd0);
    check("never_when_busy", 64'(viol_busy),  64'd0);
    check("tx_data_idle0",  64'(viol_dat),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
